// File: rtl/mod_pkg.sv
// Shared types and constants for the modulation-envelope half-period detector.
package mod_pkg;

    typedef logic [15:0] half_period_t;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    typedef enum logic {
        EDGE_RISE,
        EDGE_ANY
    } edge_mode_t;

    localparam half_period_t MAX_HALF_PERIOD_DEFAULT = 16'hFFFF;
    localparam int           MATCH_W                 = 4;

    function automatic half_period_t abs_diff(input half_period_t a, input half_period_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Optional N-flop synchronizer followed by a registered edge detector. When en is low the
// detector freezes (prior level and pending pulse held) so an edge is not lost across a pause.
module sync_edge_detect
    import mod_pkg::*;
#(
    parameter int         STAGES = 2,
    parameter edge_mode_t MODE   = EDGE_ANY
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic pulse
);

    logic level;
    logic level_prev;
    logic hit;

    generate
        if (STAGES == 0) begin : g_direct
            assign level = din;
        end else begin : g_sync
            logic [STAGES-1:0] sync_ff;

            // NOTE: non-blocking assignments make every flop sample the pre-edge value,
            // so the chain shifts by exactly one stage per clock.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_ff <= '0;
                end else begin
                    sync_ff[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        sync_ff[i] <= sync_ff[i-1];
                    end
                end
            end

            assign level = sync_ff[STAGES-1];
        end
    endgenerate

    assign hit = (MODE == EDGE_RISE) ? (level & ~level_prev) : (level ^ level_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            level_prev <= 1'b0;
            pulse      <= 1'b0;
        end else if (en) begin
            level_prev <= level;
            pulse      <= hit;
        end
    end

endmodule

// File: rtl/mod_detector.sv
// Measures the half-period of an asynchronous modulation envelope in sync ticks and
// reports lock once LOCK_COUNT consecutive measurements agree within TOLERANCE.
module mod_detector
    import mod_pkg::*;
#(
    parameter int           LOCK_COUNT      = 2,
    parameter half_period_t TOLERANCE       = 16'd0,
    parameter half_period_t MAX_HALF_PERIOD = MAX_HALF_PERIOD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sync,
    input  logic         det_enable,
    input  logic         mod_in,
    output half_period_t meas_half_period,
    output logic         meas_valid,
    output logic         locked,
    output logic         timeout
);

    localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_MAX = '1;

    logic tick;
    logic mod_edge;

    state_t             state, state_n;
    half_period_t       count, count_n, count_inc;
    logic [MATCH_W-1:0] match_cnt, match_n, match_inc;
    half_period_t       meas_n;
    logic               valid_n;
    logic               timeout_n;

    sync_edge_detect #(.STAGES(0), .MODE(EDGE_RISE)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .din   (sync),
        .pulse (tick)
    );

    // Frozen while disabled so an envelope edge during the pause is delivered on re-enable.
    sync_edge_detect #(.STAGES(2), .MODE(EDGE_ANY)) u_mod (
        .clk   (clk),
        .rst   (rst),
        .en    (det_enable),
        .din   (mod_in),
        .pulse (mod_edge)
    );

    // A tick coinciding with an edge is counted before the capture.
    assign count_inc = (tick && (count != MAX_HALF_PERIOD)) ? count + 16'd1 : count;
    assign match_inc = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_n   = state;
        count_n   = count;
        match_n   = match_cnt;
        meas_n    = meas_half_period;
        valid_n   = 1'b0;
        timeout_n = 1'b0;

        if (det_enable) begin
            unique case (state)
                IDLE: begin
                    if (mod_edge) begin
                        count_n = '0;
                        state_n = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (mod_edge && (count_inc == '0)) begin
                        match_n = '0;
                        state_n = MEASURE;
                    end else if (mod_edge) begin
                        meas_n  = count_inc;
                        valid_n = 1'b1;
                        count_n = '0;
                        match_n = (abs_diff(count_inc, meas_half_period) <= TOLERANCE)
                                  ? match_inc : MATCH_W'(1);
                        state_n = (match_n >= LOCK_TGT) ? LOCKED : MEASURE;
                    end else if (count_inc == MAX_HALF_PERIOD) begin
                        timeout_n = 1'b1;
                        match_n   = '0;
                        count_n   = '0;
                        state_n   = IDLE;
                    end else begin
                        count_n = count_inc;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            match_cnt        <= '0;
            meas_half_period <= '0;
            meas_valid       <= 1'b0;
            locked           <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            state            <= state_n;
            count            <= count_n;
            match_cnt        <= match_n;
            meas_half_period <= meas_n;
            meas_valid       <= valid_n;
            locked           <= (state_n == LOCKED);
            timeout          <= timeout_n;
        end
    end

endmodule

// File: tb/tb_mod_detector.sv
// Scoreboard bench: a modulation generator drives mod_in from sync ticks; expected
// meas_valid/timeout events are queued by the stimulus and popped by a monitor.
module tb_mod_detector;
    import mod_pkg::*;

    localparam half_period_t TB_MAX = 16'd40;

    logic         clk;
    logic         rst;
    logic         sync;
    logic         det_enable;
    logic         mod_in;
    half_period_t meas_half_period;
    logic         meas_valid;
    logic         locked;
    logic         timeout;

    typedef struct {
        logic         is_to;
        logic         lck;
        half_period_t value;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   dis_hits = 0;
    logic dis_window = 1'b0;

    int   gen_half    = 3;
    int   gen_cnt     = 0;
    int   gen_toggles = 0;
    logic gen_on      = 1'b0;
    logic gen_glitch  = 1'b0;

    mod_detector #(
        .LOCK_COUNT      (2),
        .TOLERANCE       (16'd0),
        .MAX_HALF_PERIOD (TB_MAX)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sync             (sync),
        .det_enable       (det_enable),
        .mod_in           (mod_in),
        .meas_half_period (meas_half_period),
        .meas_valid       (meas_valid),
        .locked           (locked),
        .timeout          (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    initial begin
        sync = 1'b0;
        forever #4 sync = ~sync;
    end

    // Modulation generator: toggles mod_in every gen_half sync ticks; gen_glitch
    // produces one pair of envelope edges a single clk apart.
    initial begin
        mod_in = 1'b0;
        forever begin
            @(posedge sync);
            if (gen_glitch) begin
                gen_glitch = 1'b0;
                mod_in = ~mod_in;
                #2;
                mod_in = ~mod_in;
            end else if (!gen_on) begin
                gen_cnt = 0;
            end else begin
                gen_cnt++;
                if (gen_cnt >= gen_half) begin
                    gen_cnt = 0;
                    mod_in = ~mod_in;
                    gen_toggles++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_meas(input half_period_t value, input logic lck);
        exp_t e;
        e.is_to = 1'b0;
        e.lck   = lck;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic push_timeout(input half_period_t value);
        exp_t e;
        e.is_to = 1'b1;
        e.lck   = 1'b0;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic wait_toggles(input int n, input int budget);
        int cyc = 0;
        while (gen_toggles < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (gen_toggles < n) check("toggle_wait_expired", 32'(gen_toggles), 32'(n));
    endtask

    task automatic wait_drain(input int budget);
        int cyc = 0;
        while (sb_q.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: every meas_valid or timeout pulse must match the next queued expectation.
    always @(negedge clk) begin
        logic [31:0] act;
        logic [31:0] req;
        exp_t        e;
        if (meas_valid || timeout) begin
            act = {13'd0, meas_valid, timeout, locked, meas_half_period};
            if (sb_q.size() == 0) begin
                check("unexpected_event", act, 32'd0);
            end else begin
                e   = sb_q.pop_front();
                req = {13'd0, ~e.is_to, e.is_to, e.lck, e.value};
                check("event", act, req);
            end
        end
        if (meas_valid && dis_window) dis_hits++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        det_enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_meas_half_period", 32'(meas_half_period), 32'd0);
        check("reset_meas_valid",       32'(meas_valid),       32'd0);
        check("reset_locked",           32'(locked),           32'd0);
        check("reset_timeout",          32'(timeout),          32'd0);
        rst        = 1'b0;
        det_enable = 1'b1;

        // Half-period 3: first edge only arms, lock on second matching measurement.
        push_meas(16'd3, 1'b0);
        push_meas(16'd3, 1'b1);
        push_meas(16'd3, 1'b1);
        gen_half = 3;
        gen_on   = 1'b1;
        wait_toggles(4, 200);

        // Change 3 -> 6 while locked.
        gen_half = 6;
        push_meas(16'd6, 1'b0);
        push_meas(16'd6, 1'b1);
        push_meas(16'd6, 1'b1);
        wait_toggles(7, 400);

        // 20-tick period with ticks 4..13 disabled: 10 ticks counted.
        gen_half = 20;
        push_meas(16'd10, 1'b0);
        repeat (3) @(posedge sync);
        @(negedge sync);
        det_enable = 1'b0;
        dis_window = 1'b1;
        repeat (10) @(posedge sync);
        @(negedge sync);
        dis_window = 1'b0;
        det_enable = 1'b1;
        check("no_valid_while_disabled", 32'(dis_hits), 32'd0);
        wait_toggles(8, 200);

        // Relock at 4, then reset mid-period while locked.
        gen_half = 4;
        push_meas(16'd4, 1'b0);
        push_meas(16'd4, 1'b1);
        wait_toggles(10, 300);
        repeat (6) @(negedge clk);
        check("locked_before_reset", 32'(locked), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_meas_half_period", 32'(meas_half_period), 32'd0);
        check("rst_meas_valid",       32'(meas_valid),       32'd0);
        check("rst_locked",           32'(locked),           32'd0);
        check("rst_timeout",          32'(timeout),          32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_meas(16'd4, 1'b0);
        push_meas(16'd4, 1'b1);
        wait_toggles(13, 300);

        // Static mod_in: one timeout after TB_MAX ticks, last value kept.
        gen_on = 1'b0;
        push_timeout(16'd4);
        wait_drain(600);
        @(negedge clk);
        check("timeout_locked",     32'(locked),           32'd0);
        check("timeout_keeps_meas", 32'(meas_half_period), 32'd4);

        // First edge after timeout is treated as from IDLE.
        gen_half = 5;
        gen_on   = 1'b1;
        push_meas(16'd5, 1'b0);
        push_meas(16'd5, 1'b1);
        wait_toggles(16, 300);

        // Edge after 5 ticks (matches), then a second edge 1 clk later with no tick.
        gen_on = 1'b0;
        repeat (4) @(posedge sync);
        @(negedge sync);
        push_meas(16'd5, 1'b1);
        gen_glitch = 1'b1;
        wait_drain(100);
        repeat (10) @(negedge clk);
        check("glitch_locked",    32'(locked),           32'd0);
        check("glitch_keeps_meas", 32'(meas_half_period), 32'd5);

        repeat (20) @(negedge clk);
        check("no_trailing_events", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_detector.md
MOD_DETECTOR -- requirements
Module: mod_detector

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 2: consecutive matching measurements required to assert locked (range 1..15).
REQ-002 SHALL have parameter TOLERANCE, default 0: maximum absolute difference, in sync ticks, for two measurements to match.
REQ-003 SHALL have parameter MAX_HALF_PERIOD, default 16'hFFFF: tick count at which a missing edge is declared a timeout.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sync  input  1  timebase in clk domain; each 0->1 transition is one tick.
REQ-007 det_enable  input  1  1 = detector runs; 0 = counter, FSM and outputs hold.
REQ-008 mod_in  input  1  asynchronous modulation envelope being measured.
REQ-009 meas_half_period  output  16  last accepted half-period, in sync ticks.
REQ-010 meas_valid  output  1  one-cycle pulse when meas_half_period updates.
REQ-011 locked  output  1  high while the last LOCK_COUNT measurements matched.
REQ-012 timeout  output  1  one-cycle pulse on timeout.

Function
REQ-013 mod_in SHALL pass through a 2-flop synchronizer; an edge is any level change of the synchronized signal.
REQ-014 A tick SHALL be sync high in the current cycle and low in the previous cycle.
REQ-015 The FSM SHALL have three states: IDLE, MEASURE and LOCKED.
REQ-016 In IDLE, the first mod_in edge SHALL clear the tick counter and move to MEASURE; no meas_valid is issued.
REQ-017 In MEASURE or LOCKED, each tick SHALL increment the tick counter (16 bit, saturating at MAX_HALF_PERIOD).
REQ-018 On an edge in MEASURE or LOCKED with count>0, the FSM SHALL load meas_half_period with count, pulse meas_valid and restart the count at 0.
REQ-019 A tick and an edge in the same cycle SHALL count the tick first, then capture.
REQ-020 If |new - previous| <= TOLERANCE, the match counter SHALL increment (saturating); otherwise it SHALL be set to 1 (the new measurement starts a run).
REQ-021 The FSM SHALL enter LOCKED when the match counter reaches LOCK_COUNT; a mismatch in LOCKED SHALL return to MEASURE and deassert locked in the same cycle that meas_valid pulses.
REQ-022 An edge with count==0 is a glitch: no meas_valid, match counter cleared, state MEASURE, locked deasserted.
REQ-023 When count reaches MAX_HALF_PERIOD, the FSM SHALL pulse timeout for one cycle, go to IDLE, clear locked and the match counter, and keep meas_half_period.
REQ-024 Latency: meas_valid SHALL assert 3 clk cycles after the first rising clk edge that samples the new mod_in level.
REQ-025 While det_enable=0, the FSM SHALL ignore ticks and edges, hold all state, and force meas_valid and timeout to 0; the synchronizer keeps running, so an edge that occurred during the disable is seen on re-enable.
REQ-026 A change of det_enable SHALL take effect on the next clk edge.

Reset
REQ-027 While rst=1, the block SHALL set: state IDLE, meas_half_period=0, meas_valid=0, locked=0, timeout=0, counters=0, synchronizer flops=0, previous-sync register=0.
REQ-028 rst SHALL override det_enable and any in-progress measurement; after release the first edge is treated as per REQ-016.

Structure
REQ-029 Shared package mod_pkg SHALL hold: half_period_t (logic [15:0]), the FSM state enum, and the default of MAX_HALF_PERIOD.
REQ-030 The 2-flop synchronizer plus edge detector SHALL be sub-module sync_edge_detect, reusable for sync tick detection.
REQ-031 meas_half_period SHALL use the same tick units as the modulation generator's half-period input, so that a loopback yields identical values.

Verification
REQ-032 Bench: clk period 2, sync toggling every 4 time units, mod_in from the modulation generator with half-period 3 -> meas_valid pulses with value 3, and locked asserts on the second matching pulse.
REQ-033 Generator half-period changed 3->6 while locked -> locked drops at the first 6 measurement, and reasserts after LOCK_COUNT measurements of 6.
REQ-034 mod_in held static for 65535+ ticks -> one timeout pulse, state IDLE, locked=0, meas_half_period keeps the last value.
REQ-035 det_enable=0 for 10 ticks mid-period -> no meas_valid during the disable; the next measurement excludes the disabled ticks.
REQ-036 rst pulsed for 2 cycles while locked -> all outputs 0 in the cycle after the reset edge, and the first post-reset edge gives no meas_valid.
REQ-037 mod_in edges 1 clk apart with no intervening tick -> no meas_valid, and locked=0.
